// File: rtl/repetition_serial_decoder_pkg.sv
// Shared definitions for the repetition-code serial decoder.
// Holds the decoder FSM state encoding and the constant helpers that
// define the majority threshold, tie detection and counter sizing for
// a given repetition factor. Imported by the top level and the voter.
package repetition_serial_decoder_pkg;

  // COLLECT: shifting in codeword bits; HOLD: presenting a decoded word
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } dec_state_t;

  // Number of bits needed to hold values 0..max_value, never less than 1
  function automatic int counter_width(input int max_value);
    if (max_value <= 1) begin
      return 1;
    end
    return $clog2(max_value + 1);
  endfunction

  // A group decodes to 1 when its ones count is strictly above this value
  function automatic int majority_threshold(input int repetition_factor);
    return repetition_factor / 2;
  endfunction

  // Only an even number of copies can split exactly in half
  function automatic bit can_tie(input int repetition_factor);
    return (repetition_factor % 2) == 0;
  endfunction

endpackage

// File: rtl/repetition_group_voter.sv
// Combinational vote over one repetition group.
// Takes the number of ones seen in a complete group of copies and reports
// the majority decision, whether the copies disagreed, and whether the
// group split evenly (only reachable for an even repetition factor).
//
// Ports:
//   ones_count     in   ones among the REPETITION_FACTOR copies of one data bit
//   majority       out  decoded data bit (ones strictly above half)
//   non_unanimous  out  copies were a mix of zeros and ones
//   tie            out  exactly half of the copies were ones
module repetition_group_voter
  import repetition_serial_decoder_pkg::*;
#(
  parameter int REPETITION_FACTOR = 3,
  parameter int ONES_WIDTH        = counter_width(REPETITION_FACTOR)
) (
  input  logic [ONES_WIDTH-1:0] ones_count,
  output logic                  majority,
  output logic                  non_unanimous,
  output logic                  tie
);

  localparam logic [ONES_WIDTH-1:0] THRESHOLD =
    ONES_WIDTH'(majority_threshold(REPETITION_FACTOR));
  localparam logic [ONES_WIDTH-1:0] ALL_COPIES = ONES_WIDTH'(REPETITION_FACTOR);
  localparam logic TIE_POSSIBLE = can_tie(REPETITION_FACTOR);

  assign majority      = (ones_count > THRESHOLD);
  assign non_unanimous = (ones_count != '0) && (ones_count != ALL_COPIES);
  // For even factors the threshold is exactly half, so equality is a tie
  assign tie           = TIE_POSSIBLE && (ones_count == THRESHOLD);

endmodule

// File: rtl/repetition_serial_decoder.sv
// Serial decoder for a bitwise repetition code.
// Each data bit arrives as REPETITION_FACTOR consecutive accepted copies,
// data bit 0 first. Every completed group is voted on; once all
// DATA_WIDTH groups are in, the word and its error flags are held for the
// consumer until a valid/ready handshake or an abort.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   abort            discard the partial word / held word, back to COLLECT
//   in_bit/in_valid  serial codeword input, accepted when in_ready is high
//   in_ready         high while collecting (and not in reset)
//   data_out         decoded word; keeps the last delivered word while collecting
//   out_valid        data_out and flags are valid (HOLD state)
//   out_ready        consumer takes the word
//   error_detected   some group of this word was not unanimous
//   error_corrected  errors seen and every group had a strict majority
//   uncorrectable    some group of this word tied
//   corrected_count  saturating count of corrected data bits since reset
module repetition_serial_decoder
  import repetition_serial_decoder_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int REPETITION_FACTOR = 3,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  in_bit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  error_detected,
  output logic                  error_corrected,
  output logic                  uncorrectable,
  output logic [CNT_WIDTH-1:0]  corrected_count
);

  localparam int REP_W = counter_width(REPETITION_FACTOR);
  localparam int BIT_W = counter_width(DATA_WIDTH - 1);

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPETITION_FACTOR - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  dec_state_t state, next_state;

  logic [REP_W-1:0]      rep_cnt;
  logic [REP_W-1:0]      ones_cnt;
  logic [REP_W-1:0]      ones_total;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] word_reg;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  err_acc;
  logic                  unc_acc;

  logic accept;
  logic group_done;
  logic word_done;
  logic handshake;
  logic vote_majority;
  logic vote_non_unanimous;
  logic vote_tie;

  // in_ready is gated by rst so nothing looks acceptable during reset
  assign in_ready   = (state == COLLECT) && !rst;
  assign out_valid  = (state == HOLD);
  // A bit presented alongside abort is thrown away
  assign accept     = in_valid && in_ready && !abort;
  assign group_done = accept && (rep_cnt == REP_LAST);
  assign word_done  = group_done && (bit_cnt == BIT_LAST);
  assign handshake  = out_valid && out_ready;

  // Ones in the group including the copy arriving this cycle
  assign ones_total = ones_cnt + REP_W'(in_bit);

  repetition_group_voter #(
    .REPETITION_FACTOR (REPETITION_FACTOR),
    .ONES_WIDTH        (REP_W)
  ) u_voter (
    .ones_count    (ones_total),
    .majority      (vote_majority),
    .non_unanimous (vote_non_unanimous),
    .tie           (vote_tie)
  );

  // Working word with the current group's decision merged in, so the final
  // group can be published to data_out in the same cycle it completes
  always_comb begin
    word_next          = word_reg;
    word_next[bit_cnt] = vote_majority;
  end

  // Per-word flags; a tie anywhere makes the word uncorrectable
  assign error_detected  = err_acc;
  assign uncorrectable   = unc_acc;
  assign error_corrected = err_acc && !unc_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  // abort wins over everything, including a handshake in the same cycle
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = COLLECT;
    end else begin
      case (state)
        COLLECT: if (word_done) next_state = HOLD;
        HOLD:    if (out_ready) next_state = COLLECT;
        default: next_state = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt         <= '0;
      ones_cnt        <= '0;
      bit_cnt         <= '0;
      word_reg        <= '0;
      data_out        <= '0;
      err_acc         <= 1'b0;
      unc_acc         <= 1'b0;
      corrected_count <= '0;
    end else if (abort || handshake) begin
      // Start a fresh word; data_out and corrected_count are left alone
      rep_cnt  <= '0;
      ones_cnt <= '0;
      bit_cnt  <= '0;
      word_reg <= '0;
      err_acc  <= 1'b0;
      unc_acc  <= 1'b0;
    end else if (accept) begin
      if (group_done) begin
        rep_cnt  <= '0;
        ones_cnt <= '0;
        word_reg <= word_next;
        err_acc  <= err_acc | vote_non_unanimous;
        unc_acc  <= unc_acc | vote_tie;
        if (vote_non_unanimous && !vote_tie && (corrected_count != '1)) begin
          corrected_count <= corrected_count + 1'b1;
        end
        if (word_done) begin
          bit_cnt  <= '0;
          data_out <= word_next;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        rep_cnt  <= rep_cnt + 1'b1;
        ones_cnt <= ones_total;
      end
    end
  end

endmodule

// File: tb/tb_repetition_serial_decoder.sv
// Self-checking bench for repetition_serial_decoder.
// Main instance uses W=8, R=3; a second instance with R=2 exercises ties.
module tb_repetition_serial_decoder;

  logic        clk;
  logic        rst;
  logic        abort;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic        error_detected;
  logic        error_corrected;
  logic        uncorrectable;
  logic [15:0] corrected_count;

  logic        r2_in_bit;
  logic        r2_in_valid;
  logic        r2_in_ready;
  logic [7:0]  r2_data_out;
  logic        r2_out_valid;
  logic        r2_out_ready;
  logic        r2_error_detected;
  logic        r2_error_corrected;
  logic        r2_uncorrectable;
  logic [15:0] r2_corrected_count;
  logic        r2_abort;

  int checks;
  int errors;
  int exp_count;
  logic [7:0] last_data;

  repetition_serial_decoder #(
    .DATA_WIDTH (8), .REPETITION_FACTOR (3), .CNT_WIDTH (16)
  ) dut (
    .clk (clk), .rst (rst), .abort (abort), .in_bit (in_bit),
    .in_valid (in_valid), .in_ready (in_ready), .data_out (data_out),
    .out_valid (out_valid), .out_ready (out_ready),
    .error_detected (error_detected), .error_corrected (error_corrected),
    .uncorrectable (uncorrectable), .corrected_count (corrected_count)
  );

  repetition_serial_decoder #(
    .DATA_WIDTH (8), .REPETITION_FACTOR (2), .CNT_WIDTH (16)
  ) dut_r2 (
    .clk (clk), .rst (rst), .abort (r2_abort), .in_bit (r2_in_bit),
    .in_valid (r2_in_valid), .in_ready (r2_in_ready), .data_out (r2_data_out),
    .out_valid (r2_out_valid), .out_ready (r2_out_ready),
    .error_detected (r2_error_detected), .error_corrected (r2_error_corrected),
    .uncorrectable (r2_uncorrectable), .corrected_count (r2_corrected_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: count ones per group, majority is more than half
  function automatic void refDecode(input int r, input logic [7:0] data, input logic [63:0] flips,
                                    output logic [7:0] dec, output logic det,
                                    output logic unc, output int corr);
    dec = '0; det = 1'b0; unc = 1'b0; corr = 0;
    for (int i = 0; i < 8; i++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < r; k++) ones += (data[i] ^ flips[i*r+k]) ? 1 : 0;
      dec[i] = (2 * ones > r);
      if (ones != 0 && ones != r) begin
        det = 1'b1;
        if (2 * ones == r) unc = 1'b1;
        else corr++;
      end
    end
  endfunction

  // Send the first n_bits of the R=3 codeword of data with flips applied
  task automatic applyStimulus(input logic [7:0] data, input logic [63:0] flips,
                               input int n_bits, input bit gaps);
    int wait_cnt;
    for (int idx = 0; idx < n_bits; idx++) begin
      if (gaps) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = data[idx/3] ^ flips[idx];
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge right after the last accepted bit
  task automatic checkWord(input string tag, input logic [7:0] exp_data, input logic det,
                           input logic unc, input int hold);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(data_out), 32'(exp_data));
    checkOutput({tag, "_det"}, 32'(error_detected), 32'(det));
    checkOutput({tag, "_corr"}, 32'(error_corrected), 32'(det && !unc));
    checkOutput({tag, "_unc"}, 32'(uncorrectable), 32'(unc));
    checkOutput({tag, "_count"}, 32'(corrected_count), 32'(exp_count));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom_range(0, 1));
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_data"}, 32'(data_out), 32'(exp_data));
      checkOutput({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_post_data"}, 32'(data_out), 32'(exp_data));
    last_data = exp_data;
  endtask

  task automatic runWord(input string tag, input logic [7:0] data, input logic [63:0] flips,
                         input bit gaps, input int hold);
    logic [7:0] dec;
    logic det, unc;
    int corr;
    refDecode(3, data, flips, dec, det, unc, corr);
    exp_count += corr;
    applyStimulus(data, flips, 24, gaps);
    checkWord(tag, dec, det, unc, hold);
  endtask

  initial begin
    logic [63:0] flips;
    logic [7:0]  data;
    logic [7:0]  r2_dec;
    logic        r2_det, r2_unc;
    int          r2_corr;

    checks = 0; errors = 0; exp_count = 0; last_data = '0;
    rst = 1'b1; abort = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    r2_in_bit = 1'b0; r2_in_valid = 1'b0; r2_out_ready = 1'b0; r2_abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data", 32'(data_out), 32'd0);
    checkOutput("reset_count", 32'(corrected_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    runWord("clean_a5", 8'hA5, 64'd0, 1'b0, 0);
    flips = '0; flips[10] = 1'b1;
    runWord("flip_a5", 8'hA5, flips, 1'b0, 0);
    flips = '0; flips[0] = 1'b1; flips[1] = 1'b1;
    runWord("miscorrect_00", 8'h00, flips, 1'b0, 0);
    checkOutput("miscorrect_const", 32'(last_data), 32'h01);

    // Consumer stalls for 10 cycles while bits keep being offered
    runWord("stall", 8'h5A, 64'd0, 1'b0, 10);
    runWord("after_stall", 8'hC7, 64'd0, 1'b0, 0);

    // Abort after 13 bits; group 0 completed with a correction first
    data = 8'($urandom);
    flips = '0; flips[1] = 1'b1;
    exp_count += 1;
    applyStimulus(data, flips, 13, 1'b0);
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_det", 32'(error_detected), 32'd0);
    checkOutput("abort_count", 32'(corrected_count), 32'(exp_count));
    checkOutput("abort_data", 32'(data_out), 32'(last_data));
    runWord("after_abort_3c", 8'h3C, 64'd0, 1'b0, 0);

    // Abort and handshake together while holding a word with an error
    flips = '0; flips[5] = 1'b1;
    exp_count += 1;
    applyStimulus(8'h96, flips, 24, 1'b0);
    checkOutput("hold_abort_pre", 32'(out_valid), 32'd1);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    checkOutput("hold_abort_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_abort_det", 32'(error_detected), 32'd0);
    checkOutput("hold_abort_ready", 32'(in_ready), 32'd1);
    checkOutput("hold_abort_count", 32'(corrected_count), 32'(exp_count));
    runWord("after_hold_abort", 8'h81, 64'd0, 1'b0, 0);

    // Reset pulse in the middle of a word
    flips = '0; flips[4] = 1'b1;
    applyStimulus(8'hFF, flips, 5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_data", 32'(data_out), 32'd0);
    checkOutput("midrst_count", 32'(corrected_count), 32'd0);
    checkOutput("midrst_det", 32'(error_detected), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    last_data = '0;
    flips = '0; flips[7] = 1'b1;
    runWord("after_rst", 8'h6E, flips, 1'b0, 0);

    // Random words with random error patterns per group
    for (int n = 0; n < 20; n++) begin
      data  = 8'($urandom);
      flips = '0;
      for (int g = 0; g < 8; g++) begin
        int mode;
        int a;
        mode = $urandom_range(0, 5);
        a    = $urandom_range(0, 2);
        if (mode == 1 || mode == 2) begin
          flips[g*3+a] = 1'b1;
        end else if (mode == 3) begin
          flips[g*3+a] = 1'b1;
          flips[g*3+((a+1)%3)] = 1'b1;
        end else if (mode == 4) begin
          flips[g*3] = 1'b1; flips[g*3+1] = 1'b1; flips[g*3+2] = 1'b1;
        end
      end
      runWord("rand", data, flips, 1'b1, $urandom_range(0, 3));
    end

    // R=2: data bit 6 sent as 1,0 is a tie
    data  = 8'hC3;
    flips = '0; flips[13] = 1'b1;
    refDecode(2, data, flips, r2_dec, r2_det, r2_unc, r2_corr);
    for (int idx = 0; idx < 16; idx++) begin
      @(negedge clk);
      r2_in_valid = 1'b1;
      r2_in_bit   = data[idx/2] ^ flips[idx];
      checkOutput("r2_in_ready", 32'(r2_in_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    r2_in_valid = 1'b0;
    checkOutput("r2_out_valid", 32'(r2_out_valid), 32'd1);
    checkOutput("r2_data", 32'(r2_data_out), 32'(r2_dec));
    checkOutput("r2_bit6", 32'(r2_data_out[6]), 32'd0);
    checkOutput("r2_unc", 32'(r2_uncorrectable), 32'(r2_unc));
    checkOutput("r2_det", 32'(r2_error_detected), 32'(r2_det));
    checkOutput("r2_corr", 32'(r2_error_corrected), 32'(r2_det && !r2_unc));
    checkOutput("r2_count", 32'(r2_corrected_count), 32'(r2_corr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repetition_serial_decoder.md
REPETITION_SERIAL_DECODER -- requirements
Module: repetition_serial_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, decoded word width in bits (>=1).
REQ-002 SHALL have parameter REPETITION_FACTOR, default 3, copies transmitted per data bit (>=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the corrected-bit counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 abort  input  1  synchronous discard of the partially received word.
REQ-007 in_bit  input  1  serial codeword bit.
REQ-008 in_valid  input  1  in_bit is valid this cycle.
REQ-009 in_ready  output  1  decoder accepts in_bit this cycle.
REQ-010 data_out  output  DATA_WIDTH  decoded word.
REQ-011 out_valid  output  1  data_out and the flags are valid.
REQ-012 out_ready  input  1  consumer accepts data_out.
REQ-013 error_detected  output  1  at least one repetition group in the word was not unanimous.
REQ-014 error_corrected  output  1  error_detected and every group had a strict majority.
REQ-015 uncorrectable  output  1  at least one group tied (possible only for even REPETITION_FACTOR).
REQ-016 corrected_count  output  CNT_WIDTH  saturating count of data bits corrected since reset.

Function
REQ-017 Bit order SHALL be: data bit 0 first; each data bit arrives as REPETITION_FACTOR consecutive accepted bits.
REQ-018 An input bit SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-019 FSM states SHALL be COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-020 In COLLECT, rep_cnt (0..R-1), bit_cnt (0..W-1) and ones_cnt (0..R) SHALL advance on each accepted bit; ones_cnt adds in_bit.
REQ-021 On completion of a group, data bit[bit_cnt] SHALL be 1 iff ones > R/2 (integer division), else 0.
REQ-022 A group SHALL be non-unanimous iff 0 < ones < R; tied iff 2*ones == R.
REQ-023 A non-unanimous, non-tied group SHALL increment corrected_count by 1, saturating at all-ones.
REQ-024 On acceptance of the final bit of the final group, the FSM SHALL enter HOLD; out_valid asserts the next cycle (latency 1 cycle from last accepted bit).
REQ-025 data_out and all three flags SHALL be stable while in HOLD and reflect the whole word.
REQ-026 In HOLD, out_valid=1 and out_ready=1 SHALL return the FSM to COLLECT with counters and per-word flags cleared; a new bit is accepted no earlier than the following cycle.
REQ-027 abort=1 SHALL, in either state, return to COLLECT, clear counters, per-word flags and out_valid next cycle, and discard any in_bit presented that cycle; corrected_count is unchanged.
REQ-028 abort and a completing handshake in the same cycle SHALL resolve as abort.
REQ-029 In COLLECT, data_out SHALL hold the previously delivered word (0 after reset).
REQ-030 Arithmetic SHALL use counter widths of $clog2(R+1) and $clog2(W) (minimum 1 bit); no overflow is possible.

Reset
REQ-031 rst=1 SHALL asynchronously force COLLECT, all counters 0, data_out=0, out_valid=0, all flags 0, corrected_count=0.
REQ-032 Reset mid-word SHALL discard the partial word; the first accepted bit after release is bit 0, copy 0.
REQ-033 in_ready SHALL be 0 while rst=1.

Structure
REQ-034 The FSM state encoding and the majority/tie helper constants SHALL reside in the shared ECC package.
REQ-035 One sub-module, repetition_group_voter (ones count in, majority/non-unanimous/tie out, combinational), SHALL be instantiated.

Verification (W=8, R=3 unless stated)
REQ-036 Clean codeword for 0xA5 sent without gaps -> data_out=0xA5, error_detected=0, error_corrected=0, uncorrectable=0, corrected_count=0.
REQ-037 0xA5 with the second copy of data bit 3 flipped -> data_out=0xA5, error_detected=1, error_corrected=1, corrected_count=1.
REQ-038 0x00 with two copies of bit 0 flipped -> data_out=0x01, error_detected=1, error_corrected=1 (miscorrection).
REQ-039 out_ready=0 for 10 cycles after a word -> out_valid and data_out held, in_ready=0, no bits accepted; out_ready=1 -> in_ready=1 the next cycle.
REQ-040 abort after 13 bits, then clean 0x3C -> data_out=0x3C; rst pulsed after 5 bits of a word -> all outputs 0 and the next full word decodes correctly.
REQ-041 R=2, bit 6 sent as 1,0 -> data bit 6=0, uncorrectable=1, error_corrected=0, corrected_count unchanged.
